// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPIO command master: FSM state codes, command codes
// and the o_gpo word layout.
package gpio_cmd_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [7:0] CMD_RESET    = 8'd0;
  localparam logic [7:0] CMD_EN_TX    = 8'd1;
  localparam logic [7:0] CMD_EN_RX    = 8'd2;
  localparam logic [7:0] CMD_PH_SEL   = 8'd3;
  localparam logic [7:0] CMD_RUN_MEM  = 8'd4;
  localparam logic [7:0] CMD_READ_MEM = 8'd5;
  localparam logic [7:0] CMD_ADDR_MEM = 8'd6;

  localparam int unsigned CMD_MSB  = 31;
  localparam int unsigned CMD_LSB  = 24;
  localparam int unsigned EN_BIT   = 23;
  localparam int unsigned DATA_MSB = 22;

  function automatic logic [31:0] pack_gpo(input logic [7:0] cmd, input logic en,
                                           input logic [22:0] data);
    logic [31:0] w;
    w = '0;
    w[CMD_MSB:CMD_LSB] = cmd;
    w[EN_BIT]          = en;
    w[DATA_MSB:0]      = data;
    return w;
  endfunction

endpackage

// File: rtl/gpio_cmd_master.sv
// Drives a command/enable/data word onto o_gpo with timed setup, strobe and
// response-latency phases, then captures i_gpi. Optional: GPIO_CMD_MASTER_TXN_CNT_EN.
module gpio_cmd_master
  import gpio_cmd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned RSP_LAT    = 4
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd,
  input  logic [22:0] i_cmd_data,
  output logic [31:0] o_gpo,
  input  logic [31:0] i_gpi,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_busy
`ifdef GPIO_CMD_MASTER_TXN_CNT_EN
  ,
  output logic [15:0] o_txn_count
`endif
);

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] RSP_LD    = 8'(RSP_LAT - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [7:0]  cmd_r;
  logic [22:0] data_r;
  logic [31:0] rsp_data;

  // One down-counter times every phase; each phase ends when it reaches zero.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cmd_r    <= '0;
      data_r   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            cmd_r  <= i_cmd;
            data_r <= i_cmd_data;
            state  <= ST_SETUP;
            cnt    <= SETUP_LD;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state <= ST_STROBE;
            cnt   <= STROBE_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            state <= ST_WAIT;
            cnt   <= RSP_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_data <= i_gpi;
            state    <= ST_RESP;
            cnt      <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef GPIO_CMD_MASTER_TXN_CNT_EN
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_txn_count <= '0;
    end else if (state == ST_RESP && i_rsp_ready) begin
      o_txn_count <= o_txn_count + 16'd1;
    end
  end
`endif

  // Enable is decoded from state, so reset clears it in the very next cycle.
  always_comb begin
    o_gpo       = pack_gpo(cmd_r, state == ST_STROBE, data_r);
    o_cmd_ready = (state == ST_IDLE);
    o_busy      = (state != ST_IDLE);
    o_rsp_valid = (state == ST_RESP);
    o_rsp_data  = rsp_data;
  end

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Self-checking bench: default-timing and all-one-cycle instances share stimulus and
// are each compared every cycle to an arithmetic timeline model.
module tb_gpio_cmd_master;

  localparam int unsigned NU = 2;
  localparam int unsigned S[NU] = '{2, 1};
  localparam int unsigned B[NU] = '{2, 1};
  localparam int unsigned L[NU] = '{4, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic [22:0] cmd_data;
  logic [31:0] gpi;
  logic        rsp_ready;

  logic        cmd_ready [NU];
  logic [31:0] gpo       [NU];
  logic        rsp_valid [NU];
  logic [31:0] rsp_data  [NU];
  logic        busy      [NU];
`ifdef GPIO_CMD_MASTER_TXN_CNT_EN
  logic [15:0] txn_count [NU];
`endif

  always #5 clk = ~clk;

  gpio_cmd_master #(.SETUP_CYC(S[0]), .STROBE_CYC(B[0]), .RSP_LAT(L[0])) dut0 (
    .clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready[0]),
    .i_cmd(cmd), .i_cmd_data(cmd_data), .o_gpo(gpo[0]), .i_gpi(gpi),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data[0]),
    .o_busy(busy[0])
`ifdef GPIO_CMD_MASTER_TXN_CNT_EN
    , .o_txn_count(txn_count[0])
`endif
  );

  gpio_cmd_master #(.SETUP_CYC(S[1]), .STROBE_CYC(B[1]), .RSP_LAT(L[1])) dut1 (
    .clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready[1]),
    .i_cmd(cmd), .i_cmd_data(cmd_data), .o_gpo(gpo[1]), .i_gpi(gpi),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data[1]),
    .o_busy(busy[1])
`ifdef GPIO_CMD_MASTER_TXN_CNT_EN
    , .o_txn_count(txn_count[1])
`endif
  );

  // Model: k counts cycles since acceptance (1 = first SETUP cycle); 0 means idle.
  int unsigned m_k    [NU];
  logic [7:0]  m_cmd  [NU];
  logic [22:0] m_data [NU];
  logic [31:0] m_rsp  [NU];
  int unsigned m_txn  [NU];
  int unsigned rises  [NU];
  int unsigned accepts[NU];
  logic        prev_en[NU];

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_next();
    for (int u = 0; u < NU; u++) begin
      int unsigned t;
      t = S[u] + B[u] + L[u];
      if (rst) begin
        m_k[u] = 0; m_cmd[u] = '0; m_data[u] = '0; m_rsp[u] = '0; m_txn[u] = 0;
      end else if (m_k[u] == 0) begin
        if (cmd_valid) begin
          m_k[u] = 1; m_cmd[u] = cmd; m_data[u] = cmd_data; accepts[u]++;
        end
      end else if (m_k[u] <= t) begin
        if (m_k[u] == t) m_rsp[u] = gpi;
        m_k[u]++;
      end else if (rsp_ready) begin
        m_k[u] = 0;
        m_txn[u] = (m_txn[u] + 1) % 65536;
      end
    end
  endtask

  task automatic check_all();
    for (int u = 0; u < NU; u++) begin
      logic en;
      logic [31:0] exp_gpo;
      en = (m_k[u] > S[u]) && (m_k[u] <= S[u] + B[u]);
      exp_gpo = {m_cmd[u], en, m_data[u]};
      check($sformatf("gpo%0d", u), gpo[u], exp_gpo);
      check($sformatf("ready%0d", u), {31'd0, cmd_ready[u]}, {31'd0, m_k[u] == 0});
      check($sformatf("busy%0d", u), {31'd0, busy[u]}, {31'd0, m_k[u] != 0});
      check($sformatf("rsp_valid%0d", u), {31'd0, rsp_valid[u]},
            {31'd0, m_k[u] > S[u] + B[u] + L[u]});
      check($sformatf("rsp_data%0d", u), rsp_data[u], m_rsp[u]);
`ifdef GPIO_CMD_MASTER_TXN_CNT_EN
      check($sformatf("txn%0d", u), {16'd0, txn_count[u]}, m_txn[u]);
`endif
      if (gpo[u][23] === 1'b1 && prev_en[u] !== 1'b1) rises[u]++;
      prev_en[u] = gpo[u][23];
    end
  endtask

  task automatic tick();
    model_next();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int unsigned guard;
    for (int u = 0; u < NU; u++) begin
      m_k[u] = 0; m_cmd[u] = '0; m_data[u] = '0; m_rsp[u] = '0; m_txn[u] = 0;
      rises[u] = 0; accepts[u] = 0; prev_en[u] = 1'b0;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_data = '0; gpi = '0; rsp_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Command 1/1 with a stalled host and a fixed read-back word.
    cmd_valid = 1'b1; cmd = 8'd1; cmd_data = 23'd1; gpi = 32'hDEADBEEF;
    tick();
    check("first_setup_word", gpo[0], 32'h01000001);
    cmd_valid = 1'b0; cmd = 8'd5;
    for (int i = 0; i < 24; i++) tick();
    check("stalled_rsp", rsp_data[0], 32'hDEADBEEF);
    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;

    // Back-to-back commands, valid held high with a changing command code.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd = 8'd3; cmd_data = 23'h2;
    tick();
    cmd = 8'd4; cmd_data = 23'h0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cmd = 8'($urandom_range(0, 255));
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("rises_match_accepts0", rises[0], accepts[0]);
    check("rises_match_accepts1", rises[1], accepts[1]);

    // Reset during the second strobe cycle of the default-timing instance.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd = 8'd5; cmd_data = 23'h5A5A5;
    guard = 0;
    while (!(m_k[0] == S[0] + 2) && guard < 50) begin
      tick();
      cmd_valid = 1'b0;
      guard++;
    end
    check("reach_strobe2", {31'd0, guard < 50}, 32'd1);
    rst = 1'b1;
    tick();
    check("post_rst_gpo", gpo[0], 32'h0);
    rst = 1'b0;
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd       = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) cmd = 8'($urandom);
      cmd_data  = 23'($urandom);
      gpi       = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 3);
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
